// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: sequences writes/reads into a single-port-per-direction
// memory, checks its registered read data and captures the first failing read.
module mbist_march_ctrl #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 10,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              we,
  output logic [AWIDTH-1:0] wraddr,
  output logic [DWIDTH-1:0] datain,
  output logic              re,
  output logic [AWIDTH-1:0] rdaddr,
  input  logic [DWIDTH-1:0] dataout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [AWIDTH-1:0] fail_addr,
  output logic [DWIDTH-1:0] fail_data,
  output logic [2:0]        fail_elem
);

  localparam logic [AWIDTH-1:0] ADDR_MAX = '1;

  // M1..M4 share the RD/WR pair; the active element lives in elem.
  typedef enum logic [2:0] {
    S_IDLE, S_M0, S_RD, S_WR, S_M5, S_DRAIN, S_DONE
  } state_t;

  state_t            state, nxt_state;
  logic [2:0]        elem, nxt_elem;
  logic [AWIDTH-1:0] addr, nxt_addr;

  // Read issued last cycle, waiting for its registered data.
  logic              cmp_valid;
  logic [AWIDTH-1:0] cmp_addr;
  logic [2:0]        cmp_elem;

  logic              we_d, re_d, busy_d, done_d;
  logic [AWIDTH-1:0] wraddr_d, rdaddr_d;
  logic [DWIDTH-1:0] datain_d, exp_val;
  logic              mismatch, abort, start_ok, last_addr;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    nxt_state = state;
    nxt_elem  = elem;
    nxt_addr  = addr;

    exp_val   = (cmp_elem == 3'd2 || cmp_elem == 3'd4) ? '1 : '0;
    mismatch  = cmp_valid && (dataout != exp_val);
    abort     = mismatch && (STOP_ON_FAIL != 0);
    start_ok  = start && (state == S_IDLE || state == S_DONE);
    last_addr = (elem >= 3'd3) ? (addr == '0) : (addr == ADDR_MAX);

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          nxt_state = S_M0;
          nxt_elem  = 3'd0;
          nxt_addr  = '0;
        end
      end
      S_M0: begin
        if (addr == ADDR_MAX) begin
          nxt_state = S_RD;
          nxt_elem  = 3'd1;
          nxt_addr  = '0;
        end else begin
          nxt_addr = addr + AWIDTH'(1);
        end
      end
      S_RD: nxt_state = S_WR;
      S_WR: begin
        if (abort) begin
          nxt_state = S_DONE;
        end else if (last_addr) begin
          if (elem == 3'd4) begin
            nxt_state = S_M5;
            nxt_elem  = 3'd5;
            nxt_addr  = ADDR_MAX;
          end else begin
            nxt_state = S_RD;
            nxt_elem  = elem + 3'd1;
            // M3 and M4 walk downward from the top address.
            nxt_addr  = (elem >= 3'd2) ? ADDR_MAX : '0;
          end
        end else begin
          nxt_state = S_RD;
          nxt_addr  = (elem >= 3'd3) ? addr - AWIDTH'(1) : addr + AWIDTH'(1);
        end
      end
      S_M5: begin
        if (abort)              nxt_state = S_DONE;
        else if (addr == '0)    nxt_state = S_DRAIN;
        else                    nxt_addr  = addr - AWIDTH'(1);
      end
      S_DRAIN: nxt_state = S_DONE;
      default: nxt_state = S_IDLE;
    endcase

    // Memory-side outputs are derived from the next state so they register in step with it.
    we_d     = (nxt_state == S_M0) || (nxt_state == S_WR);
    re_d     = (nxt_state == S_RD) || (nxt_state == S_M5);
    wraddr_d = we_d ? nxt_addr : '0;
    rdaddr_d = re_d ? nxt_addr : '0;
    datain_d = (nxt_state == S_WR && nxt_elem[0]) ? '1 : '0;
    busy_d   = !(nxt_state == S_IDLE || nxt_state == S_DONE);
    done_d   = (nxt_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      elem      <= '0;
      addr      <= '0;
      cmp_valid <= 1'b0;
      cmp_addr  <= '0;
      cmp_elem  <= '0;
      we        <= 1'b0;
      re        <= 1'b0;
      wraddr    <= '0;
      rdaddr    <= '0;
      datain    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_elem <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state     <= nxt_state;
      elem      <= nxt_elem;
      addr      <= nxt_addr;
      we        <= we_d;
      re        <= re_d;
      wraddr    <= wraddr_d;
      rdaddr    <= rdaddr_d;
      datain    <= datain_d;
      busy      <= busy_d;
      done      <= done_d;
      // A read in flight when the run aborts is never checked.
      cmp_valid <= re && !abort;
      cmp_addr  <= rdaddr;
      cmp_elem  <= (state == S_M5) ? 3'd5 : elem;

      if (start_ok) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        fail_elem <= '0;
      end else if (mismatch) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= cmp_addr;
          fail_data <= dataout;
          fail_elem <= cmp_elem;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two instances (stop / continue on fail), each with a faultable
// memory, checked against an op-list March C- reference model.
module tb_mbist_march_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NOPS  = 160;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    elem;
  } op_t;

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  logic          we_w[2], re_w[2], busy_w[2], done_w[2], fail_w[2];
  logic [AW-1:0] wraddr_w[2], rdaddr_w[2], fail_addr_w[2];
  logic [DW-1:0] datain_w[2], dout[2], fail_data_w[2];
  logic [2:0]    fail_elem_w[2];

  mbist_march_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .STOP_ON_FAIL(1)) u_dut_stop (
    .clk(clk), .rst(rst), .start(start),
    .we(we_w[0]), .wraddr(wraddr_w[0]), .datain(datain_w[0]),
    .re(re_w[0]), .rdaddr(rdaddr_w[0]), .dataout(dout[0]),
    .busy(busy_w[0]), .done(done_w[0]), .fail(fail_w[0]),
    .fail_addr(fail_addr_w[0]), .fail_data(fail_data_w[0]), .fail_elem(fail_elem_w[0])
  );

  mbist_march_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .STOP_ON_FAIL(0)) u_dut_cont (
    .clk(clk), .rst(rst), .start(start),
    .we(we_w[1]), .wraddr(wraddr_w[1]), .datain(datain_w[1]),
    .re(re_w[1]), .rdaddr(rdaddr_w[1]), .dataout(dout[1]),
    .busy(busy_w[1]), .done(done_w[1]), .fail(fail_w[1]),
    .fail_addr(fail_addr_w[1]), .fail_data(fail_data_w[1]), .fail_elem(fail_elem_w[1])
  );

  // Fault per memory: bits in fm at address fa read back as fv (fa = -1: fault-free).
  int            fa[2];
  logic [DW-1:0] fm[2], fv[2];
  logic [DW-1:0] mem[2][DEPTH];

  function automatic logic [DW-1:0] rd_val(int i, logic [AW-1:0] a, logic [DW-1:0] d);
    return (int'(a) == fa[i]) ? ((d & ~fm[i]) | (fv[i] & fm[i])) : d;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (re_w[i]) dout[i] <= rd_val(i, rdaddr_w[i], mem[i][rdaddr_w[i]]);
      if (we_w[i]) mem[i][wraddr_w[i]] <= datain_w[i];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] outs(int i);
    return {we_w[i], re_w[i], wraddr_w[i], rdaddr_w[i], datain_w[i], busy_w[i], done_w[i],
            fail_w[i], fail_addr_w[i], fail_data_w[i], fail_elem_w[i]};
  endfunction

  // Reference model results
  op_t           exp_ops[2][NOPS];
  int            exp_n[2], exp_busy[2];
  logic          exp_fail[2];
  logic [AW-1:0] exp_faddr[2];
  logic [DW-1:0] exp_fdata[2];
  logic [2:0]    exp_felem[2];
  op_t           obs_ops[2][NOPS+8];
  int            obs_n[2];

  task automatic model(input int i, input bit stop);
    op_t           seq[$];
    op_t           op;
    logic [DW-1:0] m[DEPTH];
    logic [DW-1:0] got, want;
    int            a;
    for (int k = 0; k < DEPTH; k++) begin
      op = '0; op.wr = 1'b1; op.addr = AW'(k);
      seq.push_back(op);
    end
    for (int e = 1; e <= 4; e++) begin
      for (int k = 0; k < DEPTH; k++) begin
        a = (e <= 2) ? k : DEPTH - 1 - k;
        op = '0; op.addr = AW'(a); op.elem = 3'(e);
        seq.push_back(op);
        op.wr = 1'b1; op.data = (e % 2 == 1) ? '1 : '0;
        seq.push_back(op);
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      op = '0; op.addr = AW'(DEPTH - 1 - k); op.elem = 3'd5;
      seq.push_back(op);
    end
    exp_fail[i] = 1'b0; exp_faddr[i] = '0; exp_fdata[i] = '0; exp_felem[i] = '0;
    exp_busy[i] = NOPS + 1;
    exp_n[i]    = NOPS;
    for (int idx = 0; idx < NOPS; idx++) begin
      op = seq[idx];
      exp_ops[i][idx] = op;
      if (op.wr) begin
        m[op.addr] = op.data;
      end else begin
        got  = rd_val(i, op.addr, m[op.addr]);
        want = (op.elem == 3'd2 || op.elem == 3'd4) ? '1 : '0;
        if (got != want) begin
          if (!exp_fail[i]) begin
            exp_faddr[i] = op.addr; exp_fdata[i] = got; exp_felem[i] = op.elem;
          end
          exp_fail[i] = 1'b1;
          if (stop) begin
            exp_busy[i] = idx + 2;
            exp_n[i]    = (idx + 2 > NOPS) ? NOPS : idx + 2;
            break;
          end
        end
      end
    end
  endtask

  task automatic do_run(input bit hold);
    int  cyc;
    int  busy_cnt[2], done_cyc[2], viol[2], bad_ops[2];
    op_t op;
    for (int i = 0; i < 2; i++) begin
      model(i, i == 0);
      obs_n[i] = 0; busy_cnt[i] = 0; done_cyc[i] = 0; viol[i] = 0; bad_ops[i] = 0;
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (!hold) start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      for (int i = 0; i < 2; i++) begin
        if (cyc == 1) begin
          check($sformatf("start_clr%0d", i), {busy_w[i], done_w[i], fail_w[i]}, 3'b100);
        end
        if (we_w[i] && re_w[i]) viol[i]++;
        if (busy_w[i] && (we_w[i] || re_w[i]) && obs_n[i] < NOPS + 8) begin
          op = '0; op.wr = we_w[i];
          op.addr = we_w[i] ? wraddr_w[i] : rdaddr_w[i];
          op.data = we_w[i] ? datain_w[i] : '0;
          obs_ops[i][obs_n[i]] = op;
          obs_n[i]++;
        end
        if (busy_w[i]) busy_cnt[i]++;
        if (done_w[i] && done_cyc[i] == 0) done_cyc[i] = cyc;
      end
      if (done_cyc[0] != 0 && done_cyc[1] != 0) break;
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < exp_n[i] && k < obs_n[i]; k++) begin
        op = exp_ops[i][k]; op.elem = '0;
        if (obs_ops[i][k] != op) bad_ops[i]++;
      end
      check($sformatf("done_cycle%0d", i), done_cyc[i], exp_busy[i] + 1);
      check($sformatf("busy_cycles%0d", i), busy_cnt[i], exp_busy[i]);
      check($sformatf("op_count%0d", i), obs_n[i], exp_n[i]);
      check($sformatf("op_order%0d", i), bad_ops[i], 0);
      check($sformatf("we_re_excl%0d", i), viol[i], 0);
      check($sformatf("fail%0d", i), fail_w[i], exp_fail[i]);
      check($sformatf("fail_addr%0d", i), fail_addr_w[i], exp_faddr[i]);
      check($sformatf("fail_data%0d", i), fail_data_w[i], exp_fdata[i]);
      check($sformatf("fail_elem%0d", i), fail_elem_w[i], exp_felem[i]);
    end
    if (hold) begin
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 2; i++)
        check($sformatf("restart%0d", i), {busy_w[i], done_w[i], fail_w[i]}, 3'b100);
      rst = 1'b0;
      @(negedge clk); rst = 1'b1;
    end
  endtask

  task automatic set_fault(input int i, input int a, input logic [DW-1:0] m, input logic [DW-1:0] v);
    fa[i] = a; fm[i] = m; fv[i] = v;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
    set_fault(0, -1, '0, '0);
    set_fault(1, -1, '0, '0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("reset_outs%0d", i), outs(i), '0);
    rst = 1'b1;

    // Clean run on both instances
    do_run(1'b0);

    // Stuck bit0=1 at addr 5 (stop instance), bit31 stuck-at-0 at addr 9 (continue instance)
    set_fault(0, 5, 32'h1, 32'h1);
    set_fault(1, 9, 32'h8000_0000, 32'h0);
    do_run(1'b0);
    check("t2_elem", fail_elem_w[0], 3'd1);
    check("t3_data", fail_data_w[1], 32'h7FFF_FFFF);

    // start held high: ignored while busy, restart accepted from DONE; prior fail cleared
    set_fault(0, -1, '0, '0);
    set_fault(1, -1, '0, '0);
    do_run(1'b1);

    // Reset pulse in the middle of M3
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (89) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("mid_rst_outs%0d", i), outs(i), '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("post_rst_idle%0d", i), {busy_w[i], done_w[i]}, 2'b00);
    do_run(1'b0);

    // Random single-bit faults
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(3) == 0) set_fault(i, -1, '0, '0);
        else set_fault(i, int'($urandom_range(DEPTH - 1)), DW'(1) << $urandom_range(DW - 1),
                       ($urandom_range(1) == 1) ? '1 : '0);
      end
      do_run(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
